// File: rtl/imem_loader.sv
// Boot loader: receives a length/data/checksum framed byte stream, writes the
// assembled 32-bit words into instruction memory and holds the core in reset until the image is verified.
module imem_loader #(
    parameter int unsigned WORDS     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        imem_we_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_wdata_o,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned ASM_W  = 24;
    localparam int unsigned ADDR_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [7:0]        xor_q, xor_d;
    logic [ASM_W-1:0]  asm_q, asm_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              byte_ready_q, busy_q, done_q, error_q, core_reset_q;

    logic              accept_c;
    logic [LEN_W-1:0]  n_c;
    logic [ADDR_W-1:0] word_addr_c;
    logic              loading_c;

    assign accept_c    = byte_valid_i && byte_ready_q;
    assign n_c         = {byte_data_i, len_q[7:0]};
    assign word_addr_c = BASE_ADDR + (ADDR_W'(k_q) << 2);
    assign loading_c   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                         (state_d == S_DATA) || (state_d == S_CSUM);

    // Next-state, word assembly and write-port control
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        k_d     = k_q;
        xor_d   = xor_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_LEN0;
                    k_d     = '0;
                    xor_d   = '0;
                    asm_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_LEN0: begin
                if (accept_c) begin
                    len_d   = {8'h00, byte_data_i};
                    xor_d   = xor_q ^ byte_data_i;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept_c) begin
                    len_d = n_c;
                    xor_d = xor_q ^ byte_data_i;
                    if (32'(n_c) > WORDS) begin
                        state_d = S_ERROR;
                    end else if (n_c == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    xor_d = xor_q ^ byte_data_i;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = word_addr_c;
                        wdata_d = {byte_data_i, asm_q};
                        asm_d   = '0;
                        bcnt_d  = '0;
                        k_d     = k_q + LEN_W'(1);
                        if (k_q + LEN_W'(1) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        // Little-endian: earlier bytes drift toward bit 0
                        asm_d  = {byte_data_i, asm_q[ASM_W-1:8]};
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    state_d = (byte_data_i == xor_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            k_q          <= '0;
            xor_q        <= '0;
            asm_q        <= '0;
            bcnt_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            k_q          <= k_d;
            xor_q        <= xor_d;
            asm_q        <= asm_d;
            bcnt_q       <= bcnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            byte_ready_q <= loading_c;
            busy_q       <= loading_c;
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
            core_reset_q <= (state_d != S_DONE);
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_reset_o = core_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
